// File: rtl/psram_spi_arbiter.sv
// psram_spi_arbiter
//   Owns a 64 Mbit serial PSRAM (SPI mode 0, single-bit SIO0/SIO1) from power-up.
//   After reset it waits PWRUP_CYCLES, then sends Reset Enable (0x66) and Reset (0x99).
//   Each command is followed by a ce_n-high gap.
//   It then serves single-byte reads (0x03) and writes (0x02) for two requesters, which
//   share the device round-robin.
//
// Ports
//   sys_clk, sys_reset_n      clock, asynchronous active-low reset
//   req_valid/we/addr/wdata   per-port request; port i uses addr[23*i+:23], wdata[8*i+:8]
//   req_ready[1:0]            one-cycle grant pulse; request fields latched this cycle
//   rsp_valid[1:0]            one-cycle pulse on completion of a read for that port
//   rsp_rdata[7:0]            read byte, held until the next read completes
//   init_done                 high once the device reset sequence has been sent
//   ce_n, sclk, mosi, miso    PSRAM pads
module psram_spi_arbiter #(
  parameter int PWRUP_CYCLES   = 4050,
  parameter int CE_HIGH_CYCLES = 2
) (
  input  logic        sys_clk,
  input  logic        sys_reset_n,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_we,
  input  logic [45:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        init_done,
  output logic        ce_n,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso
);

  localparam int CNT_MAX = (PWRUP_CYCLES > CE_HIGH_CYCLES) ? PWRUP_CYCLES : CE_HIGH_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PWRUP_LOAD = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(CE_HIGH_CYCLES - 1);

  typedef enum logic [3:0] {
    S_PWRUP, S_RSTEN, S_GAP1, S_RST, S_GAP2,
    S_IDLE, S_CMD, S_ADDR, S_DATA, S_GAPX
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic             phase_q, phase_d;
  logic             port_q, port_d;
  logic             we_q, we_d;
  logic             rr_last_q, rr_last_d;
  logic             init_done_q, init_done_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_rdata_q, rsp_rdata_d;
  logic [39:0]      tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;

  logic             in_frame;
  logic             last_bit;
  logic             gnt;

  // ce_n is low exactly while a command frame is being clocked out.
  assign in_frame = (state_q == S_RSTEN) || (state_q == S_RST) || (state_q == S_CMD) ||
                    (state_q == S_ADDR)  || (state_q == S_DATA);
  // Phase 1 of the final bit of the current state's field.
  assign last_bit = in_frame && phase_q && (bit_cnt_q == 5'd0);

  assign ce_n      = ~in_frame;
  assign sclk      = in_frame & phase_q;
  assign mosi      = in_frame & tx_q[39];
  assign init_done = init_done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    phase_d     = phase_q;
    port_d      = port_q;
    we_d        = we_q;
    rr_last_d   = rr_last_q;
    init_done_d = init_done_q;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = rsp_rdata_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    req_ready   = 2'b00;
    gnt         = 1'b0;

    // Shared bit engine: mosi changes with phase 0, miso is captured on the
    // edge that closes phase 1, and the next bit is shifted up at that edge.
    if (in_frame) begin
      phase_d = ~phase_q;
      if (phase_q) begin
        tx_d      = {tx_q[38:0], 1'b0};
        rx_d      = {rx_q[6:0], miso};
        bit_cnt_d = bit_cnt_q - 5'd1;
      end
    end

    case (state_q)
      S_PWRUP: begin
        if (cnt_q == '0) begin
          state_d   = S_RSTEN;
          tx_d      = {8'h66, 32'h0};
          bit_cnt_d = 5'd7;
          phase_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RSTEN: begin
        if (last_bit) begin
          state_d = S_GAP1;
          cnt_d   = GAP_LOAD;
        end
      end
      S_GAP1: begin
        if (cnt_q == '0) begin
          state_d   = S_RST;
          tx_d      = {8'h99, 32'h0};
          bit_cnt_d = 5'd7;
          phase_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RST: begin
        if (last_bit) begin
          state_d = S_GAP2;
          cnt_d   = GAP_LOAD;
        end
      end
      S_GAP2: begin
        if (cnt_q == '0) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_IDLE: begin
        if (init_done_q && (req_valid != 2'b00)) begin
          // On a tie the port that did not win last time is served.
          if (req_valid == 2'b11) gnt = ~rr_last_q;
          else                    gnt = req_valid[1];
          req_ready = gnt ? 2'b10 : 2'b01;
          port_d    = gnt;
          rr_last_d = gnt;
          we_d      = req_we[gnt];
          // Whole frame preloaded: command, 24-bit address (bit 23 = 0), data.
          tx_d      = {(req_we[gnt] ? 8'h02 : 8'h03), 1'b0,
                       (gnt ? req_addr[45:23] : req_addr[22:0]),
                       (gnt ? req_wdata[15:8] : req_wdata[7:0])};
          bit_cnt_d = 5'd7;
          phase_d   = 1'b0;
          state_d   = S_CMD;
        end
      end
      S_CMD: begin
        if (last_bit) begin
          state_d   = S_ADDR;
          bit_cnt_d = 5'd23;
        end
      end
      S_ADDR: begin
        if (last_bit) begin
          state_d   = S_DATA;
          bit_cnt_d = 5'd7;
        end
      end
      S_DATA: begin
        if (last_bit) begin
          state_d = S_GAPX;
          cnt_d   = GAP_LOAD;
          if (!we_q) begin
            rsp_valid_d = port_q ? 2'b10 : 2'b01;
            rsp_rdata_d = {rx_q[6:0], miso};
          end
        end
      end
      S_GAPX: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_PWRUP;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q     <= S_PWRUP;
      cnt_q       <= PWRUP_LOAD;
      bit_cnt_q   <= 5'd0;
      phase_q     <= 1'b0;
      port_q      <= 1'b0;
      we_q        <= 1'b0;
      rr_last_q   <= 1'b1;
      init_done_q <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      phase_q     <= phase_d;
      port_q      <= port_d;
      we_q        <= we_d;
      rr_last_q   <= rr_last_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Shift registers only carry data; every output using them is gated by state.
  always_ff @(posedge sys_clk) begin
    tx_q <= tx_d;
    rx_q <= rx_d;
  end

endmodule

// File: tb/tb_psram_spi_arbiter.sv
module tb_psram_spi_arbiter;

  localparam int PW       = 10;
  localparam int CE       = 2;
  localparam int INIT_END = PW + 16 + CE + 16 + CE;

  logic        sys_clk = 1'b0;
  logic        sys_reset_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_we = 2'b00;
  logic [45:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        miso = 1'b0;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        init_done;
  logic        ce_n;
  logic        sclk;
  logic        mosi;

  psram_spi_arbiter #(.PWRUP_CYCLES(PW), .CE_HIGH_CYCLES(CE)) dut (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .init_done(init_done), .ce_n(ce_n), .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc;
  always @(posedge sys_clk or negedge sys_reset_n)
    if (!sys_reset_n) cyc <= 0;
    else              cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Device contents before any write: a fixed function of the address.
  function automatic logic [7:0] seed_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h2C;
  endfunction

  function automatic logic [22:0] pool(input int k);
    case (k)
      0: return 23'h123456;
      1: return 23'h000010;
      2: return 23'h7FFFFF;
      3: return 23'h400000;
      4: return 23'h000000;
      5: return 23'h2AAAAA;
      6: return 23'h555555;
      default: return 23'h0000FF;
    endcase
  endfunction

  typedef struct {
    int          port;
    bit          we;
    logic [22:0] addr;
    logic [7:0]  data;
    int          rdy_cyc;
  } txn_t;

  // Reference model: expected grants/responses from request-level rules.
  txn_t        txq[$];
  logic [7:0]  ref_mem [int];
  int          idle_from = INIT_END;
  int          rsp_due = -1;
  int          rsp_port = 0;
  logic [7:0]  rsp_exp = 8'h00;
  bit          last_gnt = 1'b1;
  bit          prev_init = 1'b0;

  // PSRAM device model: decodes frames from the pads, answers reads on miso.
  logic [7:0]  slv_mem [int];
  bit          prev_ce_n = 1'b1;
  int          init_frames = 0;
  int          fstart = 0;
  int          nbits = 0;
  logic [39:0] bits = '0;
  logic [7:0]  sl_cmd = 8'h00;
  logic [7:0]  sl_byte = 8'h00;

  function automatic logic [7:0] ref_rd(input logic [22:0] a);
    int key = int'({9'b0, a});
    return ref_mem.exists(key) ? ref_mem[key] : seed_byte({1'b0, a});
  endfunction

  function automatic logic [7:0] slv_rd(input logic [23:0] a);
    int key = int'({8'b0, a});
    return slv_mem.exists(key) ? slv_mem[key] : seed_byte(a);
  endfunction

  always @(negedge sys_clk) begin : mon
    logic [1:0] exp_rdy;
    int p;
    txn_t t;
    if (!sys_reset_n) begin
      txq.delete();
      idle_from   = INIT_END;
      rsp_due     = -1;
      last_gnt    = 1'b1;
      prev_init   = 1'b0;
      prev_ce_n   = 1'b1;
      init_frames = 0;
      nbits       = 0;
      miso        = 1'b0;
    end else begin
      exp_rdy = 2'b00;
      if (cyc >= idle_from) begin
        if (req_valid == 2'b11) exp_rdy = last_gnt ? 2'b01 : 2'b10;
        else                    exp_rdy = req_valid;
      end
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      if (exp_rdy != 2'b00) begin
        p         = exp_rdy[1] ? 1 : 0;
        last_gnt  = (p == 1);
        t.port    = p;
        t.we      = req_we[p];
        t.addr    = req_addr[23*p +: 23];
        t.data    = req_wdata[8*p +: 8];
        t.rdy_cyc = cyc;
        txq.push_back(t);
        idle_from = cyc + 81 + CE;
        if (t.we) begin
          ref_mem[int'({9'b0, t.addr})] = t.data;
        end else begin
          rsp_due  = cyc + 81;
          rsp_port = p;
          rsp_exp  = ref_rd(t.addr);
        end
      end

      chk("rsp_valid", 32'(rsp_valid),
          (cyc == rsp_due) ? (rsp_port == 1 ? 32'd2 : 32'd1) : 32'd0);
      if (cyc == rsp_due) chk("rsp_rdata", 32'(rsp_rdata), 32'(rsp_exp));

      if (init_done !== prev_init) chk("init_done_cycle", cyc, INIT_END);
      prev_init = init_done;

      if (!ce_n) begin
        if (prev_ce_n) begin
          fstart = cyc;
          nbits  = 0;
          bits   = '0;
          if (init_frames < 2) chk("init_start", cyc, (init_frames == 0) ? PW : PW + 16 + CE);
          else if (txq.size() == 0) chk("frame_unexpected", 32'd1, 32'd0);
          else chk("frame_start", cyc, txq[0].rdy_cyc + 1);
        end
        if (sclk) begin
          bits = {bits[38:0], mosi};
          nbits++;
          if (nbits == 32) begin
            sl_cmd  = bits[31:24];
            sl_byte = slv_rd(bits[23:0]);
          end
        end else if (nbits >= 32 && nbits < 40 && sl_cmd == 8'h03) begin
          miso = sl_byte[39 - nbits];
        end
      end else begin
        miso = 1'b0;
        chk("sclk_idle", 32'(sclk), 32'd0);
        if (!prev_ce_n) begin
          if (init_frames < 2) begin
            chk("init_len", cyc - fstart, 16);
            chk("init_bits", nbits, 8);
            chk("init_cmd", 32'(bits[7:0]), (init_frames == 0) ? 32'h66 : 32'h99);
            init_frames++;
          end else if (txq.size() != 0) begin
            t = txq.pop_front();
            chk("frame_len", cyc - fstart, 80);
            chk("frame_bits", nbits, 40);
            chk("frame_cmd", 32'(bits[39:32]), t.we ? 32'h02 : 32'h03);
            chk("frame_addr", 32'(bits[31:8]), 32'({1'b0, t.addr}));
            if (t.we) chk("frame_wdata", 32'(bits[7:0]), 32'(t.data));
            if (bits[39:32] == 8'h02) slv_mem[int'({8'b0, bits[31:8]})] = bits[7:0];
          end
        end
      end
      prev_ce_n = ce_n;
    end
  end

  task automatic set_port(input int p, input bit we, input logic [22:0] a, input logic [7:0] d);
    req_we[p]          = we;
    req_addr[23*p +: 23] = a;
    req_wdata[8*p +: 8]  = d;
    req_valid[p]       = 1'b1;
  endtask

  task automatic issue(input int p, input bit we, input logic [22:0] a, input logic [7:0] d);
    bit got = 1'b0;
    @(posedge sys_clk); #1;
    set_port(p, we, a, d);
    for (int k = 0; k < 400; k++) begin
      @(negedge sys_clk);
      if (req_ready[p]) begin got = 1'b1; break; end
    end
    if (!got) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge sys_clk); #1;
    req_valid[p] = 1'b0;
  endtask

  task automatic wait_quiet();
    bit done = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(posedge sys_clk); #1;
      if (txq.size() == 0 && req_valid == 2'b00 && cyc >= idle_from) begin done = 1'b1; break; end
    end
    if (!done) chk("quiet_timeout", 32'd0, 32'd1);
  endtask

  task automatic rand_traffic(input int n);
    logic [1:0] rdy;
    for (int c = 0; c < n + 600; c++) begin
      @(negedge sys_clk);
      rdy = req_ready;
      @(posedge sys_clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && rdy[i]) req_valid[i] = 1'b0;
        if (c < n && !req_valid[i] && $urandom_range(0, 99) < 25)
          set_port(i, bit'($urandom_range(0, 1)), pool($urandom_range(0, 7)),
                   8'($urandom_range(0, 255)));
      end
      if (c >= n && req_valid == 2'b00) break;
    end
    if (req_valid != 2'b00) chk("traffic_drain", 32'(req_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ce_n"}, 32'(ce_n), 32'd1);
    chk({tag, "_sclk"}, 32'(sclk), 32'd0);
    chk({tag, "_mosi"}, 32'(mosi), 32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    chk({tag, "_init_done"}, 32'(init_done), 32'd0);
  endtask

  initial begin : wdog
    #600000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin : stim
    int k;
    bit g;
    bit got;
    // Reset state, with requests pending that must not be granted.
    req_valid = 2'b11;
    repeat (3) @(posedge sys_clk);
    #1;
    check_reset_outputs("reset");
    req_valid = 2'b00;
    #1 sys_reset_n = 1'b1;

    // Write raised during init; granted only once init is done.
    issue(0, 1'b1, 23'h123456, 8'hA5);
    wait_quiet();
    // Read of an unwritten address: device returns 0x3C.
    issue(1, 1'b0, 23'h000010, 8'h00);
    wait_quiet();

    // Both held: grants alternate 0,1,0,1.
    @(posedge sys_clk); #1;
    set_port(0, 1'b1, pool(0), 8'h11);
    set_port(1, 1'b0, pool(0), 8'h00);
    k = 0;
    for (int c = 0; c < 1000 && k < 4; c++) begin
      @(negedge sys_clk);
      if (req_ready != 2'b00) begin
        g = req_ready[1];
        chk("alt_grant", 32'(g), 32'(k % 2));
        k++;
        @(posedge sys_clk); #1;
        if (k < 4) set_port(int'(g), bit'($urandom_range(0, 1)), pool($urandom_range(0, 7)),
                            8'($urandom_range(0, 255)));
        else req_valid = 2'b00;
      end
    end
    chk("alt_grant_count", k, 4);
    req_valid = 2'b00;
    wait_quiet();

    rand_traffic(700);
    wait_quiet();

    // Reset in the middle of a read frame: no response, full init again.
    @(posedge sys_clk); #1;
    set_port(0, 1'b0, 23'h2AAAAA, 8'h00);
    got = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge sys_clk);
      if (req_ready[0]) begin got = 1'b1; break; end
    end
    if (!got) chk("rst_ready_timeout", 32'd0, 32'd1);
    @(posedge sys_clk); #1;
    req_valid = 2'b00;
    got = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge sys_clk); #1;
      if (!ce_n && nbits >= 20) begin got = 1'b1; break; end
    end
    if (!got) chk("rst_bit20_timeout", 32'd0, 32'd1);
    sys_reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(posedge sys_clk);
    #2 sys_reset_n = 1'b1;

    rand_traffic(700);
    wait_quiet();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
